// File: rtl/vending_machine_def.sv
// vending_machine_def: coin denominations, balance width and payout state encoding
// shared by the coin-return and change-calculation stages.
package vending_machine_def;

    localparam int kNumCoins = 3;
    localparam int kBalW     = 32;

    localparam logic [kBalW-1:0] kCoinValue0 = 100;
    localparam logic [kBalW-1:0] kCoinValue1 = 500;
    localparam logic [kBalW-1:0] kCoinValue2 = 1000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        DISPENSE = 2'd2,
        DONE     = 2'd3
    } pay_state_e;

    function automatic logic [kBalW-1:0] coin_value(input int idx);
        return (idx == 2) ? kCoinValue2 : (idx == 1) ? kCoinValue1 : kCoinValue0;
    endfunction

endpackage

// File: rtl/coin_return_dispenser_coin_select.sv
// coin_select: greedy largest-first pick of one available denomination that fits
// in the balance; value_o is zero when nothing qualifies so callers can subtract blindly.
module coin_select
    import vending_machine_def::*;
(
    input  logic [kBalW-1:0]     balance_i,
    input  logic [kNumCoins-1:0] avail_i,
    output logic [kNumCoins-1:0] coin_o,
    output logic [kBalW-1:0]     value_o,
    output logic                 none_o
);

    always_comb begin
        coin_o  = '0;
        value_o = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (avail_i[i] && coin_value(i) <= balance_i) begin
                coin_o    = '0;
                coin_o[i] = 1'b1;
                value_o   = coin_value(i);
            end
        end
    end

    assign none_o = ~|coin_o;

endmodule

// File: rtl/coin_return_dispenser.sv
// coin_return_dispenser: latches the balance on a return request and pays it out one
// coin per cycle, then pulses o_done with whatever could not be returned.
module coin_return_dispenser
    import vending_machine_def::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_trigger_return,
    input  logic [31:0]          wait_time,
    input  logic [kBalW-1:0]     current_total,
    input  logic [kNumCoins-1:0] i_coin_avail,
    output logic [kNumCoins-1:0] o_return_coin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [kBalW-1:0]     o_residual
);

    pay_state_e           state_q;
    logic [kBalW-1:0]     balance_q;
    logic [kNumCoins-1:0] coin_q;
    logic                 busy_q;
    logic                 done_q;
    logic [kBalW-1:0]     residual_q;
    logic [31:0]          wait_prev_q;

    logic [kNumCoins-1:0] sel_coin;
    logic [kBalW-1:0]     sel_value;
    logic                 sel_none;
    logic                 timeout;
    logic                 start;

    coin_select u_coin_select (
        .balance_i (balance_q),
        .avail_i   (i_coin_avail),
        .coin_o    (sel_coin),
        .value_o   (sel_value),
        .none_o    (sel_none)
    );

    assign timeout = (wait_prev_q != '0) && (wait_time == '0);
    assign start   = (i_trigger_return || timeout) && (current_total != '0);

    // The first pick is made while in LOAD so the coin register shows it on entry to DISPENSE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            balance_q   <= '0;
            coin_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            residual_q  <= '0;
            wait_prev_q <= '0;
        end else begin
            wait_prev_q <= wait_time;
            coin_q      <= '0;
            done_q      <= 1'b0;
            residual_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        balance_q <= current_total;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    coin_q    <= sel_coin;
                    balance_q <= balance_q - sel_value;
                    state_q   <= DISPENSE;
                end
                DISPENSE: begin
                    if (sel_none) begin
                        done_q     <= 1'b1;
                        residual_q <= balance_q;
                        state_q    <= DONE;
                    end else begin
                        coin_q    <= sel_coin;
                        balance_q <= balance_q - sel_value;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_return_coin = coin_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_residual    = residual_q;

endmodule

// File: doc/coin_return_dispenser.md
Name: coin_return_dispenser

Overview:
- Downstream of the coin-return timer/trigger stage in the vending machine.
- On a return request (user trigger or wait-time expiry), latches the machine balance and pays it out one coin per cycle, greedy largest-first, honouring per-denomination availability.
- Reports busy, a one-cycle completion pulse, and any unreturnable residual so the balance stage can clear its total.

Parameters:
- kNumCoins, 3, number of denominations (index 0 = smallest).
- kCoinValue0, 100, value of coin index 0.
- kCoinValue1, 500, value of coin index 1.
- kCoinValue2, 1000, value of coin index 2.
- kBalW, 32, balance/total width in currency units.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_trigger_return  input  1  user return request, level sampled each cycle.
- wait_time  input  32  countdown from the timer stage.
- current_total  input  kBalW  balance held by the balance stage.
- i_coin_avail  input  kNumCoins  bit i=1: denomination i can be dispensed.
- o_return_coin  output  kNumCoins  one-hot coin emitted this cycle; 0 = none.
- o_busy  output  1  high from LOAD through DONE; upstream must block coin input and selection while high.
- o_done  output  1  one-cycle pulse; payout finished; balance stage clears current_total.
- o_residual  output  kBalW  amount that could not be returned; valid while o_done=1.

Behaviour:
- Reset (async assert, sync release): state=IDLE, balance=0, o_return_coin=0, o_busy=0, o_done=0, o_residual=0, wait_prev=0.
- wait_prev is a registered copy of wait_time; timeout event = (wait_prev!=0 && wait_time==0). Only the 1→0 edge counts; a wait_time held at 0 never re-fires.
- start = (i_trigger_return || timeout) && current_total!=0.
- IDLE: on start, latch balance<=current_total and go to LOAD. No coin is emitted and o_busy=0 in the cycle start is seen.
- LOAD (1 cycle): o_busy=1, no coin emitted, go to DISPENSE.
- DISPENSE, each cycle: choose the highest i with i_coin_avail[i]=1 and kCoinValue_i<=balance. Emit one-hot bit i on o_return_coin (registered, so visible the following cycle) and subtract kCoinValue_i from balance. If no coin qualifies, emit 0 and go to DONE.
- First coin appears 2 cycles after the start cycle. An N-coin payout gives N consecutive coin cycles and no gaps unless availability changes mid-payout.
- i_coin_avail is sampled every DISPENSE cycle. Dropping a bit mid-payout falls through to smaller coins.
- DONE (1 cycle): o_done=1, o_residual=balance (e.g. a 50 remainder or unavailable denominations), o_return_coin=0, then go to IDLE.
- o_busy=0 in IDLE only. In the cycle after DONE the block is in IDLE and accepts a new start.
- Triggers and timeouts arriving while o_busy=1 are ignored and not queued.
- current_total changes after latch are ignored until the next start.
- Balance arithmetic is unsigned kBalW and never underflows, because a coin is chosen only if its value <= balance.
- Reset mid-payout aborts immediately: outputs go to 0, no o_done, and coins already emitted stay emitted.

Decomposition:
- Shared vending_machine_def package holds kNumCoins, the coin values, kBalW and state encodings (IDLE, LOAD, DISPENSE, DONE).
- One sub-module is natural: coin_select, combinational. Inputs are balance and i_coin_avail; outputs are one-hot coin, coin value and a none-flag. It is reused by the change-calculation stage.

Test Plan:
- total=1700, all avail, trigger pulse at cycle t -> coins 100b,010b,001b,001b at t+2..t+5; o_done at t+6 with o_residual=0; o_busy high t+1..t+6.
- total=1750, all avail, wait_time 1→0 -> same four coins; o_residual=50; wait_time held at 0 afterwards causes no restart.
- total=1000, avail=011b -> 010b,010b, then o_done with o_residual=0.
- total=600, trigger held high during payout, current_total changed to 2000 mid-payout -> coins 010b,001b only; single o_done; restart in IDLE only because trigger is still high.
- total=2000, reset_n asserted after first coin -> all outputs 0 immediately, no o_done; after release, IDLE with o_busy=0.
- total=0 with trigger, or total=80 with avail=000b -> total=0: no start, o_busy stays 0; total=80: LOAD, DISPENSE, DONE with o_residual=80 and no coins.
